// File: rtl/spec_op_dispatcher.sv
// -----------------------------------------------------------------------------
// spec_op_dispatcher
//
// Buffers {op, dst, src} commands in a small FIFO and hands them one at a time
// to a specialized unit (FFT / encrypt / decrypt). For each command it waits
// for the unit's completion (or gives up after TIMEOUT cycles) and presents a
// single response through a valid/ready handshake.
//
// Parameters
//   DEPTH   : command FIFO entries (power of two, >= 2)
//   TIMEOUT : cycles spent in WAIT for su_done before an error response
//
// Ports
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (cmd_ready = FIFO not full)
//   cmd_op/dst/src        : operation code, destination and source addresses
//   su_op_code/su_R1/su_R2: issue to the unit; op code is 0000 except in ISSUE
//   su_result/su_done     : completion from the unit (su_done is registered)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_result/rsp_err    : captured result (0 on error), error flag
//   busy                  : FSM not idle or FIFO not empty
// -----------------------------------------------------------------------------
module spec_op_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [18:0] cmd_dst,
  input  logic [18:0] cmd_src,
  output logic [3:0]  su_op_code,
  output logic [18:0] su_R1,
  output logic [18:0] su_R2,
  input  logic [18:0] su_result,
  input  logic        su_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [18:0] rsp_result,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int EW = 4 + 19 + 19;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT);

  // Command FIFO storage
  logic [EW-1:0] fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push;
  logic          pop;

  logic [3:0]    head_op;
  logic [18:0]   head_dst;
  logic [18:0]   head_src;
  logic          head_legal;

  // Control / datapath registers
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [3:0]    su_op_q, su_op_d;
  logic [18:0]   su_r1_q, su_r1_d;
  logic [18:0]   su_r2_q, su_r2_d;
  logic [18:0]   rsp_result_q, rsp_result_d;
  logic          rsp_err_q, rsp_err_d;

  // Ready depends only on registered occupancy, so a pop in the same cycle
  // never lets a push into a full FIFO.
  assign cmd_ready = (count_q != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  // count_q excludes a push happening this cycle, so a fresh entry in an
  // empty FIFO is popped one cycle later at the earliest.
  assign pop       = (state_q == S_IDLE) && (count_q != '0);

  assign {head_op, head_dst, head_src} = fifo_mem[rd_ptr_q];
  assign head_legal = (head_op == 4'b1100) || (head_op == 4'b1101) ||
                      (head_op == 4'b1110);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {cmd_op, cmd_dst, cmd_src};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    su_op_d      = 4'b0000;      // op code is only non-zero during ISSUE
    su_r1_d      = su_r1_q;
    su_r2_d      = su_r2_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (head_legal) begin
            state_d = S_ISSUE;
            su_op_d = head_op;
            su_r1_d = head_dst;
            su_r2_d = head_src;
          end else begin
            // Illegal op never reaches the unit; answer with an error.
            state_d      = S_RESP;
            rsp_result_d = '0;
            rsp_err_d    = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end
      S_WAIT: begin
        if (su_done) begin
          state_d      = S_RESP;
          rsp_result_d = su_result;
          rsp_err_d    = 1'b0;
        end else if (tmo_q >= TMO_LAST) begin
          // This was the TIMEOUT-th WAIT cycle without completion.
          state_d      = S_RESP;
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
        end else begin
          tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= S_IDLE;
      tmo_q        <= '0;
      su_op_q      <= 4'b0000;
      su_r1_q      <= '0;
      su_r2_q      <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      su_op_q      <= su_op_d;
      su_r1_q      <= su_r1_d;
      su_r2_q      <= su_r2_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign su_op_code = su_op_q;
  assign su_R1      = su_r1_q;
  assign su_R2      = su_r2_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_spec_op_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_spec_op_dispatcher
//
// Directed scenarios (reset values, latency, illegal op, timeout and its
// boundary, response hold, FIFO full, reset mid-operation) followed by a
// randomized run. A behavioural unit model answers issues after a per-command
// delay; expected responses come from the command list by plain rules.
// -----------------------------------------------------------------------------
module tb_spec_op_dispatcher;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [18:0] cmd_dst;
  logic [18:0] cmd_src;
  logic [3:0]  su_op_code;
  logic [18:0] su_R1;
  logic [18:0] su_R2;
  logic [18:0] su_result;
  logic        su_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [18:0] rsp_result;
  logic        rsp_err;
  logic        busy;

  always #5 clk = ~clk;

  spec_op_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_dst    (cmd_dst),
    .cmd_src    (cmd_src),
    .su_op_code (su_op_code),
    .su_R1      (su_R1),
    .su_R2      (su_R2),
    .su_result  (su_result),
    .su_done    (su_done),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  // delay: WAIT cycle (1-based) in which the unit raises su_done; 0 = never
  typedef struct {
    logic [3:0]  op;
    logic [18:0] dst;
    logic [18:0] src;
    int          delay;
    logic [18:0] res;
  } cmd_t;

  typedef struct {
    logic [18:0] result;
    logic        err;
  } rsp_t;

  cmd_t su_q[$];
  rsp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   n_acc  = 0;
  int   n_done = 0;
  logic spur_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] op);
    return (op == 4'b1100) || (op == 4'b1101) || (op == 4'b1110);
  endfunction

  function automatic rsp_t expect_rsp(input cmd_t c);
    rsp_t r;
    if (!is_legal(c.op)) begin
      r.result = '0; r.err = 1'b1;
    end else if (c.delay >= 1 && c.delay <= TIMEOUT) begin
      r.result = c.res; r.err = 1'b0;
    end else begin
      r.result = '0; r.err = 1'b1;
    end
    return r;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    if ($urandom_range(0, 5) == 0) begin
      c.op = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 3) == 0) c.op = 4'hF;
    end else begin
      c.op = 4'($urandom_range(12, 14));
    end
    c.dst   = 19'($urandom);
    c.src   = 19'($urandom);
    c.delay = int'($urandom_range(1, 17));
    c.res   = 19'($urandom);
    return c;
  endfunction

  task automatic record_cmd(input cmd_t c);
    if (is_legal(c.op)) su_q.push_back(c);
    exp_q.push_back(expect_rsp(c));
    n_acc++;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compare the presented response with the oldest expected one; pop it
  // when the handshake is about to complete.
  task automatic rsp_check(input bit do_pop);
    rsp_t e;
    if (exp_q.size() == 0) begin
      check_eq("rsp_unexpected", rsp_valid, 0);
    end else begin
      e = exp_q[0];
      check_eq("rsp_result", rsp_result, e.result);
      check_eq("rsp_err", rsp_err, e.err);
      if (do_pop) begin
        void'(exp_q.pop_front());
        n_done++;
        $display("[TB] rsp %0d result=0x%05h err=%0d", n_done, rsp_result, rsp_err);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  // with cmd_valid still high.
  task automatic push_cmd(input cmd_t c);
    int guard = 0;
    cmd_valid = 1'b1; cmd_op = c.op; cmd_dst = c.dst; cmd_src = c.src;
    while (!cmd_ready && guard < 200) begin
      tick();
      guard++;
    end
    check_eq("push_ready", cmd_ready, 1);
    if (cmd_ready) record_cmd(c);
    tick();
  endtask

  task automatic collect(input int n);
    rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      while (!rsp_valid && guard < 100) begin
        tick();
        guard++;
      end
      check_eq("collect_valid", rsp_valid, 1);
      if (rsp_valid) begin
        rsp_check(1'b1);
        tick();
      end
    end
    rsp_ready = 1'b0;
  endtask

  // Behavioural specialized unit: on seeing an issue it raises su_done for
  // one cycle in the command's chosen WAIT cycle (even past the timeout, to
  // show that late completions are ignored).
  initial begin : su_model
    cmd_t cur;
    int   k;
    bit   active;
    su_done = 1'b0; su_result = '0; active = 1'b0; k = 0;
    forever begin
      @(negedge clk);
      su_done   = spur_done;
      su_result = 19'($urandom);
      if (active) begin
        k++;
        check_eq("no_reissue_op", su_op_code, 0);
        if (k == cur.delay) begin
          su_done = 1'b1; su_result = cur.res; active = 1'b0;
        end
      end else if (su_op_code != 4'b0000) begin
        if (su_q.size() == 0) begin
          check_eq("unexpected_issue", su_op_code, 0);
        end else begin
          cur = su_q.pop_front();
          check_eq("issue_op", su_op_code, cur.op);
          check_eq("issue_R1", su_R1, cur.dst);
          check_eq("issue_R2", su_R2, cur.src);
          k = 0;
          active = (cur.delay != 0);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    cmd_t c;
    int   lat;
    int   sent;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset values
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_su_op", su_op_code, 0);
    check_eq("rst_su_R1", su_R1, 0);
    check_eq("rst_su_R2", su_R2, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_result", rsp_result, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_busy", busy, 0);
    tick();

    // Single legal op: response visible in the 4th cycle from the accept edge
    c = '{op: 4'b1101, dst: 19'd5, src: 19'd3, delay: 1, res: 19'h2AAAA};
    push_cmd(c);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      tick();
      lat++;
    end
    check_eq("lat_legal", lat, 4);
    collect(1);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_rsp_valid", rsp_valid, 0);

    // Illegal op: error response, nothing issued
    c = '{op: 4'b0011, dst: 19'd7, src: 19'd9, delay: 0, res: 19'd0};
    push_cmd(c);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      check_eq("illegal_no_issue", su_op_code, 0);
      tick();
      lat++;
    end
    check_eq("lat_illegal", lat, 2);
    check_eq("illegal_no_issue_resp", su_op_code, 0);
    collect(1);

    // Timeout: no su_done at all
    c = '{op: 4'b1110, dst: 19'h12345, src: 19'h54321, delay: 0, res: 19'd0};
    push_cmd(c);
    cmd_valid = 1'b0;
    lat = 0;
    while (su_op_code == 4'b0000 && lat < 30) begin
      tick();
      lat++;
    end
    check_eq("tmo_issue_seen", su_op_code, 4'b1110);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    check_eq("tmo_cycles", lat, TIMEOUT + 1);
    collect(1);
    check_eq("tmo_busy_after", busy, 0);

    // Completion in the last allowed WAIT cycle vs one cycle too late
    c = '{op: 4'b1100, dst: 19'd1, src: 19'd2, delay: TIMEOUT, res: 19'h0F0F0};
    push_cmd(c);
    c = '{op: 4'b1101, dst: 19'd3, src: 19'd4, delay: TIMEOUT + 1, res: 19'h7FFFF};
    push_cmd(c);
    cmd_valid = 1'b0;
    collect(2);

    // Response held with rsp_ready low; a new command is accepted meanwhile
    c = '{op: 4'b1100, dst: 19'd11, src: 19'd22, delay: 2, res: 19'h13579};
    push_cmd(c);
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 30) begin
      tick();
      lat++;
    end
    c = '{op: 4'b1110, dst: 19'd33, src: 19'd44, delay: 3, res: 19'h24680};
    push_cmd(c);
    cmd_valid = 1'b0;
    spur_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_eq("hold_valid", rsp_valid, 1);
      rsp_check(1'b0);
      check_eq("hold_no_issue", su_op_code, 0);
      tick();
    end
    spur_done = 1'b0;
    tick();
    collect(2);

    // FIFO full: five back-to-back commands with the consumer stalled
    for (int i = 0; i < 5; i++) begin
      c = rand_cmd();
      c.op = 4'($urandom_range(12, 14));
      c.delay = int'($urandom_range(1, 3));
      push_cmd(c);
    end
    check_eq("full_ready", cmd_ready, 0);
    check_eq("full_busy", busy, 1);
    c = rand_cmd();
    cmd_op = c.op; cmd_dst = c.dst; cmd_src = c.src;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("full_ready_hold", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    collect(5);

    // Reset during WAIT, then a late su_done
    c = '{op: 4'b1101, dst: 19'h1ABCD, src: 19'h0DCBA, delay: 0, res: 19'd0};
    push_cmd(c);
    cmd_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    spur_done = 1'b1;
    exp_q.delete();
    su_q.delete();
    n_acc = n_done;
    check_eq("mid_rst_su_R1", su_R1, 0);
    check_eq("mid_rst_su_R2", su_R2, 0);
    check_eq("mid_rst_result", rsp_result, 0);
    check_eq("mid_rst_err", rsp_err, 0);
    check_eq("mid_rst_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      check_eq("mid_rst_valid", rsp_valid, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_op", su_op_code, 0);
      tick();
    end
    spur_done = 1'b0;
    tick();

    // Randomized traffic against the reference rules
    sent = 0;
    for (int cyc = 0; cyc < 20000 && (sent < 150 || n_done != n_acc); cyc++) begin
      check_eq("rand_busy", busy, (n_acc != n_done));
      rsp_ready = (sent >= 150) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (rsp_valid) rsp_check(rsp_ready);
      if (sent < 150 && $urandom_range(0, 2) != 0) begin
        c = rand_cmd();
        cmd_valid = 1'b1; cmd_op = c.op; cmd_dst = c.dst; cmd_src = c.src;
        if (cmd_ready) begin
          record_cmd(c);
          sent++;
        end
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();
    check_eq("final_busy", busy, 0);
    check_eq("final_rsp_valid", rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spec_op_dispatcher.md
SPEC_OP_DISPATCHER -- requirements
Module: spec_op_dispatcher

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning WAIT cycles allowed for su_done before an error response.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  FIFO can accept; equals not-full.
REQ-008 cmd_op  in  4  operation code: 1100 FFT, 1101 encrypt, 1110 decrypt.
REQ-009 cmd_dst  in  19  destination memory address.
REQ-010 cmd_src  in  19  source memory address.
REQ-011 su_op_code  out  4  op code to the specialized unit; 0000 when idle.
REQ-012 su_R1  out  19  destination address to the specialized unit.
REQ-013 su_R2  out  19  source address to the specialized unit.
REQ-014 su_result  in  19  result from the specialized unit.
REQ-015 su_done  in  1  completion from the specialized unit, registered.
REQ-016 rsp_valid  out  1  response available.
REQ-017 rsp_ready  in  1  consumer accepts response.
REQ-018 rsp_result  out  19  captured result; 0 on error.
REQ-019 rsp_err  out  1  1 = illegal op or timeout.
REQ-020 busy  out  1  high when state is not IDLE or FIFO is non-empty.

Function
REQ-021 SHALL push {op,dst,src} into the FIFO on a clock edge where cmd_valid && cmd_ready; order SHALL be preserved.
REQ-022 cmd_ready SHALL derive from registered occupancy only; no push when full, even if a pop occurs in the same cycle.
REQ-023 A push into an empty FIFO SHALL NOT be popped in the same cycle; the pop occurs no earlier than the next cycle.
REQ-024 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-025 IDLE, FIFO non-empty: SHALL pop the head into the current-command register; a legal op -> ISSUE, an illegal op -> RESP with rsp_err=1 and rsp_result=0, with no issue to the unit.
REQ-026 IDLE, FIFO empty: SHALL remain in IDLE.
REQ-027 ISSUE SHALL last exactly one cycle, drive su_op_code=op, su_R1=dst and su_R2=src, then go to WAIT and clear the timeout counter.
REQ-028 In every state other than ISSUE, su_op_code SHALL be 0000; su_R1 and su_R2 SHALL hold their last values.
REQ-029 WAIT: on the first cycle with su_done=1, SHALL capture su_result into rsp_result, set rsp_err=0 and go to RESP.
REQ-030 WAIT: if TIMEOUT cycles elapse without su_done, SHALL go to RESP with rsp_err=1 and rsp_result=0.
REQ-031 su_done SHALL be ignored in every state except WAIT.
REQ-032 The timeout counter SHALL saturate and never wrap.
REQ-033 RESP SHALL assert rsp_valid with rsp_result and rsp_err stable until rsp_ready; the handshake edge SHALL return the FSM to IDLE and drop rsp_valid.
REQ-034 Legal-op latency: rsp_valid SHALL rise 4 cycles after the accepting edge when the FIFO was empty and the FSM was idle (push, pop, issue, capture).
REQ-035 The FIFO SHALL continue accepting commands in every FSM state while not full.

Reset
REQ-036 On reset the FSM SHALL enter IDLE and the FIFO SHALL be emptied (pointers and count = 0).
REQ-037 Reset values: cmd_ready=1, su_op_code=0000, su_R1=0, su_R2=0, rsp_valid=0, rsp_result=0, rsp_err=0, busy=0.
REQ-038 Reset mid-operation SHALL abandon the in-flight command with no response, and a late su_done SHALL be ignored.

Verification
REQ-039 Single op 1101, dst=5, src=3, unit returns 0x2AAAA with done one cycle after ISSUE -> rsp_valid 4 cycles after the push, rsp_result=0x2AAAA, rsp_err=0.
REQ-040 Push 5 commands back-to-back with DEPTH=4 and rsp_ready=0 -> cmd_ready low after the 4th buffered entry, responses in push order once rsp_ready=1.
REQ-041 cmd_op=0011 -> rsp_err=1, rsp_result=0, su_op_code stays 0000 throughout.
REQ-042 su_done never asserted -> rsp_err=1 after 15 WAIT cycles, rsp_result=0, FSM back to IDLE after the handshake.
REQ-043 Assert reset during WAIT, then drive su_done=1 -> no rsp_valid, FIFO empty, all outputs at their reset values.
REQ-044 rsp_ready held low 10 cycles in RESP -> rsp_result and rsp_err unchanged, no further su_op_code issue until the handshake completes.
